time_chain_ctrl: RTL and testbench
==================================

Name: time_chain_ctrl

Overview:
Sequencer for the alarm-clock time digit chain: seconds units (mod-10), seconds tens (mod-6), minutes units (mod-10), minutes tens (mod-6), hours units (mod-10), hours tens (mod-3).
- Issues one-cycle advance and load-zero strobes to those counters.
- Handles the 23:59:59 -> 00:00:00 rollover.
- Runs the user time-set mode machine driven by Mode and Inc buttons.
- Sits between the 1 Hz tick prescaler, the debounced button inputs and the digit counters.

Parameters:
REPEAT_TICKS, 2, Tick count Inc_Btn must be held before auto-repeat starts (used only with AUTO_REPEAT_EN).
BLINK_DIV, 1, Ticks per Blink toggle in set modes (>=1).

Ports:
Clk  input  1  system clock; all logic on posedge.
Clr  input  1  synchronous, active-high reset.
Tick  input  1  one-cycle 1 Hz strobe.
Mode_Btn  input  1  debounced level; rising edge advances mode.
Inc_Btn  input  1  debounced level; rising edge increments the selected field.
SU  input  4  seconds-units counter value.
ST  input  3  seconds-tens counter value.
MU  input  4  minutes-units counter value.
MT  input  3  minutes-tens counter value.
HU  input  4  hours-units counter value.
HT  input  2  hours-tens counter value.
SU_Up, ST_Up, MU_Up, MT_Up, HU_Up, HT_Up  output  1 each  one-cycle advance strobes; each counter wraps itself.
Sec_Ld  output  1  one-cycle pulse: load 0 into SU and ST.
Hr_Ld  output  1  one-cycle pulse: load 0 into HU and HT.
Mode  output  2  00 RUN, 01 SET_HR, 10 SET_MIN.
Blink  output  1  display blink flag for the field being set.

Behaviour:
- Reset (Clr=1 at posedge):
  - Mode=RUN; all strobes, Sec_Ld, Hr_Ld and Blink = 0.
  - Button edge-detect registers = 0; tick counters = 0.
- All strobe outputs are registered. Each is 1 for exactly one cycle, the cycle after the triggering event. Digit inputs are sampled in the triggering cycle.
- Button edges: edge = Btn & ~Btn_q. Btn_q is updated every cycle.
- RUN, on Tick:
  - SU_Up=1.
  - ST_Up if SU==9.
  - MU_Up if SU==9 & ST==5.
  - MT_Up if the above & MU==9.
  - Hour step if the above & MT==5:
    - if HT==2 & HU==3: Hr_Ld=1, with HU_Up=HT_Up=0;
    - else HU_Up=1, and HT_Up=1 if HU==9.
- SET_HR and SET_MIN:
  - Tick does not advance any digit.
  - Tick drives Blink: Blink toggles every BLINK_DIV ticks.
- SET_HR, on Inc edge: same hour step as RUN (23 -> Hr_Ld; x9 -> HU_Up+HT_Up; else HU_Up).
- SET_MIN, on Inc edge:
  - MU_Up; MT_Up if MU==9.
  - 59 -> 00 via the counters' own wrap; no hour carry.
- Mode transitions on Mode edge: RUN -> SET_HR -> SET_MIN -> RUN.
  - Entering SET_HR: Sec_Ld pulses (seconds zeroed); Blink set to 1; blink counter cleared.
  - Entering RUN: Blink = 0.
  - Entering SET_MIN: Blink set to 1; blink counter cleared.
- Simultaneous events:
  - Mode edge with Inc edge in the same cycle: the mode change wins and the Inc edge is discarded.
  - Mode edge with Tick in RUN: the Tick cascade is still issued for that cycle, then the mode changes.
- Mode encoding 11 is unreachable; if reached, next cycle goes to RUN with no strobes.
- Clr asserted mid-operation: pending strobes are suppressed in the next cycle. The counters themselves are not reset by this block.

Optional Feature:
AUTO_REPEAT_EN:
- Defined:
  - In SET_HR or SET_MIN, Inc_Btn held continuously for REPEAT_TICKS ticks after its rising edge produces one increment per subsequent Tick while it is held.
  - The increment has the same strobe pattern as an Inc edge.
  - The repeat counter clears on release, on a mode change and on Clr.
- Undefined: only Inc rising edges increment; held buttons do nothing further.

Test Plan:
- Reset, then RUN, counters at 00:00:58, two Ticks -> first Tick: SU_Up only. Second Tick (SU=9, ST=5): SU_Up+ST_Up+MU_Up, with MT_Up=0 (MU=0).
- RUN at 23:59:59, Tick -> SU_Up, ST_Up, MU_Up, MT_Up and Hr_Ld all =1 the next cycle; HU_Up=HT_Up=0.
- RUN at 09:59:59, Tick -> HU_Up=1 and HT_Up=1, Hr_Ld=0.
- Mode edge from RUN -> Mode=01, Sec_Ld pulse, Blink=1. Three Ticks with BLINK_DIV=1 -> Blink 0,1,0, with no Up strobes. Inc edge at HU=3, HT=2 -> Hr_Ld only.
- SET_MIN with MU=9, MT=5, Inc edge -> MU_Up+MT_Up, no hour strobes. Mode edge and Inc edge in the same cycle -> Mode=00, no strobes.
- AUTO_REPEAT_EN with REPEAT_TICKS=2: hold Inc for 5 Ticks in SET_MIN -> 1 (edge) + 3 repeat MU_Up strobes. Without the macro -> 1 strobe.

Source files
------------

// File: rtl/time_chain_ctrl.sv
// time_chain_ctrl: sequencer for the HH:MM:SS digit-counter chain.
// Issues one-cycle advance/load strobes to the six digit counters, handles
// the 23:59:59 -> 00:00:00 rollover and runs the RUN/SET_HR/SET_MIN mode
// machine driven by the debounced Mode and Inc buttons.
// Optional feature macro: AUTO_REPEAT_EN (Inc auto-repeat while held in set modes).
module time_chain_ctrl #(
  parameter int REPEAT_TICKS = 2,
  parameter int BLINK_DIV    = 1
) (
  input  logic       Clk,
  input  logic       Clr,
  input  logic       Tick,
  input  logic       Mode_Btn,
  input  logic       Inc_Btn,
  input  logic [3:0] SU,
  input  logic [2:0] ST,
  input  logic [3:0] MU,
  input  logic [2:0] MT,
  input  logic [3:0] HU,
  input  logic [1:0] HT,
  output logic       SU_Up,
  output logic       ST_Up,
  output logic       MU_Up,
  output logic       MT_Up,
  output logic       HU_Up,
  output logic       HT_Up,
  output logic       Sec_Ld,
  output logic       Hr_Ld,
  output logic [1:0] Mode,
  output logic       Blink
);

  typedef enum logic [1:0] {
    MODE_RUN     = 2'b00,
    MODE_SET_HR  = 2'b01,
    MODE_SET_MIN = 2'b10
  } mode_e;

`ifdef AUTO_REPEAT_EN
  localparam logic REP_EN = 1'b1;
`else
  localparam logic REP_EN = 1'b0;
`endif

  localparam logic [7:0] REP_LAST   = 8'(REPEAT_TICKS);
  localparam logic [7:0] BLINK_LAST = 8'(BLINK_DIV - 1);

  // Hour advance pattern {hr_ld, hu_up, ht_up}: 23 reloads, x9 carries into tens.
  function automatic logic [2:0] hour_step(input logic [3:0] hu, input logic [1:0] ht);
    if ((ht == 2'd2) && (hu == 4'd3)) begin
      return 3'b100;
    end else if (hu == 4'd9) begin
      return 3'b011;
    end else begin
      return 3'b010;
    end
  endfunction

  mode_e      mode_q, mode_d;
  logic       mode_btn_q, inc_btn_q;
  logic       su_up_q, st_up_q, mu_up_q, mt_up_q, hu_up_q, ht_up_q;
  logic       su_up_d, st_up_d, mu_up_d, mt_up_d, hu_up_d, ht_up_d;
  logic       sec_ld_q, hr_ld_q, sec_ld_d, hr_ld_d;
  logic       blink_q, blink_d;
  logic [7:0] blink_cnt_q, blink_cnt_d;
  logic [7:0] rep_cnt_q, rep_cnt_d;

  logic       mode_edge_s, inc_edge_s, inc_held_s, rep_fire_s;
  logic       sec_carry_s, min_carry_s, hour_carry_s;
  logic [2:0] hour_s;

  assign mode_edge_s  = Mode_Btn & ~mode_btn_q;
  assign inc_edge_s   = Inc_Btn & ~inc_btn_q;
  assign inc_held_s   = Inc_Btn & inc_btn_q;
  assign sec_carry_s  = (SU == 4'd9) && (ST == 3'd5);
  assign min_carry_s  = sec_carry_s && (MU == 4'd9);
  assign hour_carry_s = min_carry_s && (MT == 3'd5);
  assign hour_s       = hour_step(HU, HT);

  // Next-state and strobe decode for the mode machine, blink and repeat counters.
  always_comb begin
    mode_d      = mode_q;
    su_up_d     = 1'b0;
    st_up_d     = 1'b0;
    mu_up_d     = 1'b0;
    mt_up_d     = 1'b0;
    hu_up_d     = 1'b0;
    ht_up_d     = 1'b0;
    sec_ld_d    = 1'b0;
    hr_ld_d     = 1'b0;
    blink_d     = blink_q;
    blink_cnt_d = blink_cnt_q;
    rep_cnt_d   = rep_cnt_q;
    rep_fire_s  = 1'b0;

    case (mode_q)
      MODE_RUN: begin
        blink_d   = 1'b0;
        rep_cnt_d = 8'd0;
        // The tick cascade is issued even when the mode changes this cycle.
        if (Tick) begin
          su_up_d = 1'b1;
          st_up_d = (SU == 4'd9);
          mu_up_d = sec_carry_s;
          mt_up_d = min_carry_s;
          if (hour_carry_s) begin
            {hr_ld_d, hu_up_d, ht_up_d} = hour_s;
          end else begin
            {hr_ld_d, hu_up_d, ht_up_d} = 3'b000;
          end
        end else begin
          su_up_d = 1'b0;
        end
        if (mode_edge_s) begin
          mode_d      = MODE_SET_HR;
          sec_ld_d    = 1'b1;
          blink_d     = 1'b1;
          blink_cnt_d = 8'd0;
        end else begin
          mode_d = MODE_RUN;
        end
      end

      MODE_SET_HR, MODE_SET_MIN: begin
        if (Tick) begin
          if (blink_cnt_q >= BLINK_LAST) begin
            blink_d     = ~blink_q;
            blink_cnt_d = 8'd0;
          end else begin
            blink_cnt_d = blink_cnt_q + 8'd1;
          end
        end else begin
          blink_cnt_d = blink_cnt_q;
        end

        // Repeat counter only runs while Inc stays held past its rising edge.
        if (!REP_EN || !inc_held_s) begin
          rep_cnt_d = 8'd0;
        end else if (Tick) begin
          if (rep_cnt_q >= REP_LAST) begin
            rep_fire_s = 1'b1;
          end else begin
            rep_cnt_d = rep_cnt_q + 8'd1;
          end
        end else begin
          rep_cnt_d = rep_cnt_q;
        end

        // A mode edge wins over any increment in the same cycle.
        if (mode_edge_s) begin
          rep_cnt_d   = 8'd0;
          blink_cnt_d = 8'd0;
          if (mode_q == MODE_SET_HR) begin
            mode_d  = MODE_SET_MIN;
            blink_d = 1'b1;
          end else begin
            mode_d  = MODE_RUN;
            blink_d = 1'b0;
          end
        end else if (inc_edge_s || rep_fire_s) begin
          if (mode_q == MODE_SET_HR) begin
            {hr_ld_d, hu_up_d, ht_up_d} = hour_s;
          end else begin
            mu_up_d = 1'b1;
            mt_up_d = (MU == 4'd9);
          end
        end else begin
          mode_d = mode_q;
        end
      end

      default: begin
        mode_d      = MODE_RUN;
        blink_d     = 1'b0;
        blink_cnt_d = 8'd0;
        rep_cnt_d   = 8'd0;
      end
    endcase
  end

  // State, edge-detect and registered strobe outputs with synchronous clear.
  always_ff @(posedge Clk) begin
    if (Clr) begin
      mode_q      <= MODE_RUN;
      mode_btn_q  <= 1'b0;
      inc_btn_q   <= 1'b0;
      su_up_q     <= 1'b0;
      st_up_q     <= 1'b0;
      mu_up_q     <= 1'b0;
      mt_up_q     <= 1'b0;
      hu_up_q     <= 1'b0;
      ht_up_q     <= 1'b0;
      sec_ld_q    <= 1'b0;
      hr_ld_q     <= 1'b0;
      blink_q     <= 1'b0;
      blink_cnt_q <= 8'd0;
      rep_cnt_q   <= 8'd0;
    end else begin
      mode_q      <= mode_d;
      mode_btn_q  <= Mode_Btn;
      inc_btn_q   <= Inc_Btn;
      su_up_q     <= su_up_d;
      st_up_q     <= st_up_d;
      mu_up_q     <= mu_up_d;
      mt_up_q     <= mt_up_d;
      hu_up_q     <= hu_up_d;
      ht_up_q     <= ht_up_d;
      sec_ld_q    <= sec_ld_d;
      hr_ld_q     <= hr_ld_d;
      blink_q     <= blink_d;
      blink_cnt_q <= blink_cnt_d;
      rep_cnt_q   <= rep_cnt_d;
    end
  end

  assign SU_Up  = su_up_q;
  assign ST_Up  = st_up_q;
  assign MU_Up  = mu_up_q;
  assign MT_Up  = mt_up_q;
  assign HU_Up  = hu_up_q;
  assign HT_Up  = ht_up_q;
  assign Sec_Ld = sec_ld_q;
  assign Hr_Ld  = hr_ld_q;
  assign Mode   = mode_q;
  assign Blink  = blink_q;

endmodule

// File: tb/tb_time_chain_ctrl.sv
// Directed self-checking bench for time_chain_ctrl (REPEAT_TICKS=2, BLINK_DIV=1).
module tb_time_chain_ctrl;

  logic       Clk = 1'b0;
  logic       Clr = 1'b1;
  logic       Tick = 1'b0;
  logic       Mode_Btn = 1'b0;
  logic       Inc_Btn = 1'b0;
  logic [3:0] SU = 4'd0;
  logic [2:0] ST = 3'd0;
  logic [3:0] MU = 4'd0;
  logic [2:0] MT = 3'd0;
  logic [3:0] HU = 4'd0;
  logic [1:0] HT = 2'd0;
  logic       SU_Up, ST_Up, MU_Up, MT_Up, HU_Up, HT_Up, Sec_Ld, Hr_Ld, Blink;
  logic [1:0] Mode;
  logic [7:0] stb;

  int errors = 0;
  int checks = 0;

  // Strobe vector order: SU ST MU MT HU HT Sec_Ld Hr_Ld
  assign stb = {SU_Up, ST_Up, MU_Up, MT_Up, HU_Up, HT_Up, Sec_Ld, Hr_Ld};

  time_chain_ctrl #(.REPEAT_TICKS(2), .BLINK_DIV(1)) dut (
    .Clk(Clk), .Clr(Clr), .Tick(Tick), .Mode_Btn(Mode_Btn), .Inc_Btn(Inc_Btn),
    .SU(SU), .ST(ST), .MU(MU), .MT(MT), .HU(HU), .HT(HT),
    .SU_Up(SU_Up), .ST_Up(ST_Up), .MU_Up(MU_Up), .MT_Up(MT_Up),
    .HU_Up(HU_Up), .HT_Up(HT_Up), .Sec_Ld(Sec_Ld), .Hr_Ld(Hr_Ld),
    .Mode(Mode), .Blink(Blink)
  );

  always #5 Clk = ~Clk;

  // Advance one clock; outputs are then sampled 1 time unit after the edge.
  task automatic step();
    @(posedge Clk);
    #1;
    Tick = 1'b0;
  endtask

  task automatic set_time(input logic [1:0] ht, input logic [3:0] hu, input logic [2:0] mt,
                          input logic [3:0] mu, input logic [2:0] st, input logic [3:0] su);
    HT = ht; HU = hu; MT = mt; MU = mu; ST = st; SU = su;
  endtask

  task automatic apply_reset();
    Clr = 1'b1; Tick = 1'b0; Mode_Btn = 1'b0; Inc_Btn = 1'b0;
    step(); step();
    Clr = 1'b0;
  endtask

  task automatic press_mode();
    Mode_Btn = 1'b1;
    step();
    Mode_Btn = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset();
    checks++;
    if ({Mode, Blink, stb} !== 11'b0) begin
      $display("FAIL reset: got mode=%b blink=%b stb=%b want all zero", Mode, Blink, stb);
      errors++;
    end
    // Clr in the same cycle as a Tick suppresses the strobes.
    set_time(2'd0, 4'd0, 3'd0, 4'd0, 3'd0, 4'd1);
    Tick = 1'b1; Clr = 1'b1;
    step();
    Clr = 1'b0;
    checks++;
    if (stb !== 8'b0) begin
      $display("FAIL clr_tick: got stb=%b want 00000000", stb);
      errors++;
    end
  endtask

  task automatic test_run_carry();
    apply_reset();
    set_time(2'd0, 4'd0, 3'd0, 4'd0, 3'd5, 4'd8);
    Tick = 1'b1; step();
    checks++;
    if (stb !== 8'b1000_0000) begin
      $display("FAIL run_58: got stb=%b want 10000000", stb);
      errors++;
    end
    SU = 4'd9;
    Tick = 1'b1; step();
    checks++;
    if (stb !== 8'b1110_0000) begin
      $display("FAIL run_59: got stb=%b want 11100000", stb);
      errors++;
    end
    step();
    checks++;
    if (stb !== 8'b0) begin
      $display("FAIL one_cycle: got stb=%b want 00000000", stb);
      errors++;
    end
  endtask

  task automatic test_hour_rollover();
    apply_reset();
    set_time(2'd2, 4'd3, 3'd5, 4'd9, 3'd5, 4'd9);
    Tick = 1'b1; step();
    checks++;
    if (stb !== 8'b1111_0001) begin
      $display("FAIL midnight: got stb=%b want 11110001", stb);
      errors++;
    end
    set_time(2'd0, 4'd9, 3'd5, 4'd9, 3'd5, 4'd9);
    Tick = 1'b1; step();
    checks++;
    if (stb !== 8'b1111_1100) begin
      $display("FAIL hour_09: got stb=%b want 11111100", stb);
      errors++;
    end
    set_time(2'd1, 4'd3, 3'd5, 4'd9, 3'd5, 4'd9);
    Tick = 1'b1; step();
    checks++;
    if (stb !== 8'b1111_1000) begin
      $display("FAIL hour_13: got stb=%b want 11111000", stb);
      errors++;
    end
  endtask

  task automatic test_set_hr();
    logic exp_blink;
    apply_reset();
    set_time(2'd2, 4'd3, 3'd0, 4'd0, 3'd0, 4'd0);
    press_mode();
    checks++;
    if ({Mode, Blink, stb} !== {2'b01, 1'b1, 8'b0000_0010}) begin
      $display("FAIL enter_hr: got mode=%b blink=%b stb=%b want 01 1 00000010", Mode, Blink, stb);
      errors++;
    end
    exp_blink = 1'b1;
    for (int i = 0; i < 3; i++) begin
      Tick = 1'b1; step();
      exp_blink = ~exp_blink;
      checks++;
      if ({Blink, stb} !== {exp_blink, 8'b0}) begin
        $display("FAIL hr_tick%0d: got blink=%b stb=%b want %b 00000000", i, Blink, stb, exp_blink);
        errors++;
      end
    end
    Inc_Btn = 1'b1; step(); Inc_Btn = 1'b0;
    checks++;
    if (stb !== 8'b0000_0001) begin
      $display("FAIL hr_inc_23: got stb=%b want 00000001", stb);
      errors++;
    end
    set_time(2'd0, 4'd9, 3'd0, 4'd0, 3'd0, 4'd0);
    step();
    Inc_Btn = 1'b1; step(); Inc_Btn = 1'b0;
    checks++;
    if (stb !== 8'b0000_1100) begin
      $display("FAIL hr_inc_09: got stb=%b want 00001100", stb);
      errors++;
    end
    set_time(2'd1, 4'd4, 3'd0, 4'd0, 3'd0, 4'd0);
    step();
    Inc_Btn = 1'b1; step(); Inc_Btn = 1'b0;
    checks++;
    if (stb !== 8'b0000_1000) begin
      $display("FAIL hr_inc_14: got stb=%b want 00001000", stb);
      errors++;
    end
  endtask

  task automatic test_set_min();
    apply_reset();
    press_mode(); step();
    Tick = 1'b1; step();
    press_mode();
    checks++;
    if ({Mode, Blink, stb} !== {2'b10, 1'b1, 8'b0}) begin
      $display("FAIL enter_min: got mode=%b blink=%b stb=%b want 10 1 00000000", Mode, Blink, stb);
      errors++;
    end
    set_time(2'd2, 4'd3, 3'd5, 4'd9, 3'd0, 4'd0);
    Inc_Btn = 1'b1; step(); Inc_Btn = 1'b0;
    checks++;
    if (stb !== 8'b0011_0000) begin
      $display("FAIL min_inc_59: got stb=%b want 00110000", stb);
      errors++;
    end
    set_time(2'd0, 4'd0, 3'd2, 4'd4, 3'd0, 4'd0);
    step();
    Inc_Btn = 1'b1; step(); Inc_Btn = 1'b0;
    checks++;
    if (stb !== 8'b0010_0000) begin
      $display("FAIL min_inc_24: got stb=%b want 00100000", stb);
      errors++;
    end
    step();
    Mode_Btn = 1'b1; Inc_Btn = 1'b1; step();
    Mode_Btn = 1'b0; Inc_Btn = 1'b0;
    checks++;
    if ({Mode, Blink, stb} !== {2'b00, 1'b0, 8'b0}) begin
      $display("FAIL mode_and_inc: got mode=%b blink=%b stb=%b want 00 0 00000000", Mode, Blink, stb);
      errors++;
    end
  endtask

  task automatic test_back_to_back();
    apply_reset();
    set_time(2'd0, 4'd0, 3'd0, 4'd0, 3'd0, 4'd3);
    Tick = 1'b1; Mode_Btn = 1'b1; step(); Mode_Btn = 1'b0;
    checks++;
    if ({Mode, stb} !== {2'b01, 8'b1000_0010}) begin
      $display("FAIL tick_and_mode: got mode=%b stb=%b want 01 10000010", Mode, stb);
      errors++;
    end
    step();
    Clr = 1'b1; step(); Clr = 1'b0;
    checks++;
    if ({Mode, Blink} !== 3'b000) begin
      $display("FAIL clr_in_set: got mode=%b blink=%b want 00 0", Mode, Blink);
      errors++;
    end
  endtask

  task automatic test_hold_inc();
    int mu_cnt;
    int hr_cnt;
    int exp_mu;
`ifdef AUTO_REPEAT_EN
    exp_mu = 4;
`else
    exp_mu = 1;
`endif
    mu_cnt = 0;
    hr_cnt = 0;
    apply_reset();
    press_mode(); step(); press_mode(); step();
    set_time(2'd0, 4'd0, 3'd0, 4'd1, 3'd0, 4'd0);
    Inc_Btn = 1'b1; step();
    mu_cnt += int'(MU_Up);
    hr_cnt += int'(HU_Up | HT_Up | Hr_Ld | SU_Up);
    for (int i = 0; i < 5; i++) begin
      Tick = 1'b1; step();
      mu_cnt += int'(MU_Up);
      hr_cnt += int'(HU_Up | HT_Up | Hr_Ld | SU_Up);
      step();
      mu_cnt += int'(MU_Up);
      hr_cnt += int'(HU_Up | HT_Up | Hr_Ld | SU_Up);
    end
    Inc_Btn = 1'b0;
    Tick = 1'b1; step();
    mu_cnt += int'(MU_Up);
    checks++;
    if (mu_cnt !== exp_mu) begin
      $display("FAIL hold_inc: got %0d MU_Up strobes want %0d", mu_cnt, exp_mu);
      errors++;
    end
    checks++;
    if (hr_cnt !== 0) begin
      $display("FAIL hold_other: got %0d other strobes want 0", hr_cnt);
      errors++;
    end
  endtask

  initial begin
    test_reset();
    test_run_carry();
    test_hour_rollover();
    test_set_hr();
    test_set_min();
    test_back_to_back();
    test_hold_inc();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
